// File: rtl/bounce_generator_if.sv
// bounce_generator_if: bundles the request and observation signals of the
// bounce emulator.
//   level      requested clean contact level (master -> slave)
//   step_en    one-clk tick enable for all gap/settle timing (master -> slave)
//   out        bouncy contact output (slave -> master)
//   busy       high while an event is in progress (slave -> master)
//   stateval   FSM state: 0 IDLE, 1 BOUNCE, 2 SETTLE (slave -> master)
//   bounce_cnt glitches remaining in the current event (slave -> master)
interface bounce_generator_if;
  logic       level;
  logic       step_en;
  logic       out;
  logic       busy;
  logic [1:0] stateval;
  logic [4:0] bounce_cnt;

  modport master (output level, step_en, input out, busy, stateval, bounce_cnt);
  modport slave  (input level, step_en, output out, busy, stateval, bounce_cnt);
endinterface

// File: rtl/bounce_generator.sv
// bounce_generator: turns a clean requested level into a switch-like bouncy
// waveform so an on-chip debouncer can be exercised without a real button.
// A level change gives a first contact, then N glitches (OUT toggle pairs,
// every phase held G step ticks), then a settle window at the final level.
// N and G come from a 16-bit Fibonacci LFSR (RANDOM=1) or from parameters.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    bounce_generator_if.slave (level, step_en in; out, busy,
//          stateval, bounce_cnt out; all outputs registered)
module bounce_generator #(
  parameter bit          RANDOM        = 1'b1,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          NB_BITS       = 3,
  parameter int          GAP_BITS      = 3,
  parameter int          FIXED_BOUNCES = 3,
  parameter int          FIXED_GAP     = 2,
  parameter int          SETTLE_TICKS  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  bounce_generator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  state_t      state;
  logic [15:0] lfsr;
  logic        target;
  logic        out_q;
  logic        busy_q;
  logic [4:0]  bcnt;
  logic [7:0]  gap;
  logic [7:0]  settle;

  logic        fb;
  logic [4:0]  n_sel;
  logic [7:0]  g_sel;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Sampled from the current LFSR value; N is used only at event start,
  // G at event start and at every phase boundary.
  assign n_sel = RANDOM ? 5'(lfsr[NB_BITS-1:0]) + 5'd1 : 5'(FIXED_BOUNCES);
  assign g_sel = RANDOM ? 8'(lfsr[8+GAP_BITS-1:8]) + 8'd1 : 8'(FIXED_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lfsr   <= SEED_EFF;
      target <= 1'b0;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
      bcnt   <= 5'd0;
      gap    <= 8'd0;
      settle <= 8'd0;
    end else begin
      // Free-running so successive events see different random values.
      lfsr <= {lfsr[14:0], fb};
      case (state)
        IDLE: begin
          // Level is only compared here, so activity during an event either
          // shows up as a net change now or is lost.
          if (bus.level != target) begin
            target <= bus.level;
            out_q  <= bus.level;
            bcnt   <= n_sel;
            gap    <= g_sel;
            busy_q <= 1'b1;
            if (n_sel == 5'd0) begin
              settle <= 8'(SETTLE_TICKS);
              state  <= SETTLE;
            end else begin
              state  <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (bus.step_en) begin
            if (gap == 8'd1) begin
              out_q <= ~out_q;
              gap   <= g_sel;
              // out_q != target means this toggle lands back on target,
              // closing one glitch.
              if (out_q != target) begin
                bcnt <= bcnt - 5'd1;
                if (bcnt == 5'd1) begin
                  settle <= 8'(SETTLE_TICKS);
                  state  <= SETTLE;
                end
              end
            end else begin
              gap <= gap - 8'd1;
            end
          end
        end
        SETTLE: begin
          if (bus.step_en) begin
            settle <= settle - 8'd1;
            if (settle == 8'd1) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.out        = out_q;
  assign bus.busy       = busy_q;
  assign bus.stateval   = state;
  assign bus.bounce_cnt = bcnt;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator: three instances (fixed N=3/G=2, fixed N=0,
// random). Fixed instances are checked by a scoreboard of expected output
// changes (value, step ticks and clocks since previous change); the random
// instance by per-event properties plus an exact first event from the seed.
module tb_bounce_generator;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int KR = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bounce_generator_if if_f ();
  bounce_generator_if if_z ();
  bounce_generator_if if_r ();

  logic       lvl[3];
  logic       stp[3];
  int         mode[3];
  logic       o_out[3];
  logic [1:0] o_st[3];
  logic [4:0] o_bc[3];
  logic       o_busy[3];

  assign if_f.level = lvl[0];  assign if_f.step_en = stp[0];
  assign if_z.level = lvl[1];  assign if_z.step_en = stp[1];
  assign if_r.level = lvl[2];  assign if_r.step_en = stp[2];
  assign o_out[0] = if_f.out;  assign o_st[0] = if_f.stateval;
  assign o_bc[0]  = if_f.bounce_cnt; assign o_busy[0] = if_f.busy;
  assign o_out[1] = if_z.out;  assign o_st[1] = if_z.stateval;
  assign o_bc[1]  = if_z.bounce_cnt; assign o_busy[1] = if_z.busy;
  assign o_out[2] = if_r.out;  assign o_st[2] = if_r.stateval;
  assign o_bc[2]  = if_r.bounce_cnt; assign o_busy[2] = if_r.busy;

  bounce_generator #(.RANDOM(1'b0), .FIXED_BOUNCES(3), .FIXED_GAP(2), .SETTLE_TICKS(5))
    u_fix (.clk(clk), .rst_n(rst_n), .bus(if_f.slave));
  bounce_generator #(.RANDOM(1'b0), .FIXED_BOUNCES(0), .FIXED_GAP(2), .SETTLE_TICKS(5))
    u_zero (.clk(clk), .rst_n(rst_n), .bus(if_z.slave));
  bounce_generator #(.RANDOM(1'b1), .SEED(SEED), .NB_BITS(3), .GAP_BITS(3), .SETTLE_TICKS(5))
    u_rnd (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Tick generator: mode 0 none, 1 every 4th clk, 2 every clk.
  int scnt = 0;
  always @(negedge clk) begin
    scnt++;
    for (int k = 0; k < 3; k++)
      stp[k] = (mode[k] == 2) || (mode[k] == 1 && (scnt % 4) == 0);
  end

  // ---------------- scoreboard for the two fixed instances ----------------
  typedef struct {
    logic       out;
    logic [1:0] st;
    logic [4:0] bc;
    logic       busy;
    int         dt;   // step ticks since previous change, -1 = don't care
    int         dc;   // clocks since previous change, -1 = don't care
  } exp_t;

  exp_t expq[2][$];

  task automatic push(int k, logic o, logic [1:0] s, logic [4:0] b, logic bz, int dt, int dc);
    exp_t e;
    e.out = o; e.st = s; e.bc = b; e.busy = bz; e.dt = dt; e.dc = dc;
    expq[k].push_back(e);
  endtask

  // Expected change list for one fixed-mode event towards level l.
  task automatic push_event(int k, logic l, int n, int g, int s, int dc0);
    push(k, l, (n == 0) ? 2'd2 : 2'd1, 5'(n), 1'b1, -1, dc0);
    for (int i = 1; i <= 2 * n; i++)
      push(k, (i % 2 == 1) ? ~l : l, (i == 2 * n) ? 2'd2 : 2'd1, 5'(n - i / 2), 1'b1, g, -1);
    push(k, l, 2'd0, 5'd0, 1'b0, s, -1);
  endtask

  logic       sv[2];
  int         ticks[2];
  int         cyc[2];
  logic [8:0] prev[2];
  logic [8:0] cur;
  exp_t       me;

  initial begin
    for (int k = 0; k < 2; k++) begin prev[k] = 9'd0; ticks[k] = 0; cyc[k] = 0; end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) sv[k] = stp[k];
    #1;
    for (int k = 0; k < 2; k++) begin
      if (sv[k]) ticks[k]++;
      cyc[k]++;
      cur = {o_out[k], o_st[k], o_bc[k], o_busy[k]};
      if (cur !== prev[k]) begin
        checks++;
        if (expq[k].size() == 0) begin
          errors++;
          $display("FAIL sb%0d_unexpected actual out=%b st=%0d bc=%0d busy=%b required no change",
                   k, o_out[k], o_st[k], o_bc[k], o_busy[k]);
        end else begin
          me = expq[k].pop_front();
          if (cur !== {me.out, me.st, me.bc, me.busy} ||
              (me.dt >= 0 && ticks[k] != me.dt) || (me.dc >= 0 && cyc[k] != me.dc)) begin
            errors++;
            $display("FAIL sb%0d_change actual out=%b st=%0d bc=%0d busy=%b ticks=%0d clks=%0d required out=%b st=%0d bc=%0d busy=%b ticks=%0d clks=%0d",
                     k, o_out[k], o_st[k], o_bc[k], o_busy[k], ticks[k], cyc[k],
                     me.out, me.st, me.bc, me.busy, me.dt, me.dc);
          end
        end
        ticks[k] = 0;
        cyc[k]   = 0;
        prev[k]  = cur;
      end
    end
  end

  // ---------------- random instance monitor ----------------
  int   exp_n;
  int   exp_ph[$];
  int   rph[$];
  int   ph = 0, edges = 0, rand_events = 0;
  bit   rexact = 1'b0;
  bit   rok;
  logic rsv, rprev_busy = 1'b0, rprev_out = 1'b0;

  function automatic logic [15:0] adv(logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected first event when LEVEL rises k clocks after reset release
  // with continuous ticks: N, then the 2N phase lengths.
  task automatic calc_rand(int k);
    logic [15:0] lf;
    int g;
    lf = SEED;
    repeat (k) lf = adv(lf);
    exp_n = int'(lf[2:0]) + 1;
    g = int'(lf[10:8]) + 1;
    exp_ph.delete();
    for (int i = 0; i < 2 * exp_n; i++) begin
      exp_ph.push_back(g);
      repeat (g) lf = adv(lf);
      g = int'(lf[10:8]) + 1;
    end
  endtask

  always @(posedge clk) begin
    rsv = stp[2];
    #1;
    if (rsv) ph++;
    if (o_busy[2] && !rprev_busy) begin
      edges = 1; ph = 0; rph.delete();
    end else if (o_busy[2] && o_out[2] !== rprev_out) begin
      edges++;
      rph.push_back(ph);
      checks++;
      if (ph < 1 || ph > 8) begin
        errors++;
        $display("FAIL rand_phase actual=%0d required=1..8", ph);
      end
      ph = 0;
    end
    if (!o_busy[2] && rprev_busy) begin
      rand_events++;
      checks++;
      if (edges % 2 == 0 || edges < 3 || edges > 17) begin
        errors++;
        $display("FAIL rand_edges actual=%0d required=odd 3..17", edges);
      end
      if (rexact) begin
        rok = (edges == 1 + 2 * exp_n) && (rph.size() == exp_ph.size());
        if (rok) for (int i = 0; i < rph.size(); i++) if (rph[i] != exp_ph[i]) rok = 1'b0;
        checks++;
        if (!rok) begin
          errors++;
          $display("FAIL rand_seed_event actual edges=%0d first_phase=%0d required edges=%0d first_phase=%0d",
                   edges, (rph.size() > 0) ? rph[0] : -1, 1 + 2 * exp_n, exp_ph[0]);
        end
        rexact = 1'b0;
      end
    end
    if (!o_busy[2]) begin
      checks++;
      if (o_out[2] !== lvl[2]) begin
        errors++;
        $display("FAIL rand_idle_level actual=%b required=%b", o_out[2], lvl[2]);
      end
    end
    rprev_busy = o_busy[2];
    rprev_out  = o_out[2];
  end

  // ---------------- helpers ----------------
  task automatic wait_drain(int k, int budget, string nm);
    for (int i = 0; i < budget && expq[k].size() != 0; i++) @(negedge clk);
    chk({nm, "_pending"}, expq[k].size(), 0);
    expq[k].delete();
  endtask

  // Wait for the fixed instance to reach a given state (bc/out <0 = any).
  task automatic wait_fix(int st, int bc, int ov, int budget, string nm);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (o_st[0] == 2'(st)) && (bc < 0 || o_bc[0] == 5'(bc)) && (ov < 0 || o_out[0] == 1'(ov));
    end
    if (!hit) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_rand_idle(string nm);
    int i;
    repeat (2) @(negedge clk);
    for (i = 0; i < 1000 && o_busy[2]; i++) @(negedge clk);
    if (o_busy[2]) chk({nm, "_timeout"}, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  int issued;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin lvl[k] = 1'b0; stp[k] = 1'b0; mode[k] = 0; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out", o_out[k], 0);
      chk("rst_state", o_st[k], 0);
      chk("rst_busy", o_busy[k], 0);
      chk("rst_bcnt", o_bc[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First random event, KR clocks after release, fully predicted from SEED.
    mode[2] = 2;
    calc_rand(KR);
    repeat (KR) @(negedge clk);
    rexact = 1'b1;
    lvl[2] = 1'b1;
    issued = 1;

    // Test 1: fixed event 0->1, ticks every 4th clock.
    mode[0] = 1;
    push_event(0, 1'b1, 3, 2, 5, -1);
    lvl[0] = 1'b1;
    @(negedge clk);
    chk("t1_first_contact", o_out[0], 1);
    chk("t1_busy", o_busy[0], 1);
    chk("t1_bcnt", o_bc[0], 3);
    wait_drain(0, 2000, "t1");

    // Test 2: zero bounces, continuous ticks, 0->1 then 1->0.
    mode[1] = 2;
    push_event(1, 1'b1, 0, 2, 5, -1);
    lvl[1] = 1'b1;
    wait_drain(1, 200, "t2_rise");
    push_event(1, 1'b0, 0, 2, 5, -1);
    lvl[1] = 1'b0;
    @(negedge clk);
    chk("t2_settle_direct", o_st[1], 2);
    chk("t2_out", o_out[1], 0);
    wait_drain(1, 200, "t2_fall");

    // Test 3a: 0-pulse inside BOUNCE with no net change -> no second event.
    push_event(0, 1'b0, 3, 2, 5, -1);
    lvl[0] = 1'b0;
    wait_fix(1, -1, -1, 50, "t3a_bounce");
    repeat (3) @(negedge clk);
    lvl[0] = 1'b1;
    repeat (4) @(negedge clk);
    lvl[0] = 1'b0;
    wait_drain(0, 2000, "t3a");
    repeat (30) @(negedge clk);
    chk("t3a_no_event", o_busy[0], 0);

    // Test 3b: net change inside SETTLE -> new event on the first IDLE clock.
    push_event(0, 1'b1, 3, 2, 5, -1);
    push_event(0, 1'b0, 3, 2, 5, 1);
    lvl[0] = 1'b1;
    wait_fix(2, -1, -1, 2000, "t3b_settle");
    lvl[0] = 1'b0;
    wait_drain(0, 4000, "t3b");

    // Test 6: ticks frozen for 50 clocks mid-BOUNCE.
    push_event(0, 1'b1, 3, 2, 5, -1);
    lvl[0] = 1'b1;
    wait_fix(1, 2, 1, 2000, "t6_reach");
    mode[0] = 0;
    repeat (50) @(negedge clk);
    chk("t6_frozen_state", o_st[0], 1);
    chk("t6_frozen_bcnt", o_bc[0], 2);
    chk("t6_frozen_out", o_out[0], 1);
    mode[0] = 1;
    wait_drain(0, 2000, "t6");

    // Test 4: random mode, 200 events in total.
    wait_rand_idle("t4_first");
    while (issued < 200 || lvl[2]) begin
      lvl[2] = ~lvl[2];
      issued++;
      wait_rand_idle("t4_evt");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t4_event_count", rand_events, issued);

    // Test 5: async reset mid-BOUNCE of the fixed instance (OUT high).
    push_event(0, 1'b0, 3, 2, 5, -1);
    lvl[0] = 1'b0;
    wait_fix(1, 3, 1, 200, "t5_reach");
    @(posedge clk);
    #3;
    expq[0].delete();
    push(0, 1'b0, 2'd0, 5'd0, 1'b0, -1, -1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out", o_out[0], 0);
    chk("t5_rst_state", o_st[0], 0);
    chk("t5_rst_bcnt", o_bc[0], 0);
    chk("t5_rst_busy", o_busy[0], 0);
    lvl[0] = 1'b1;
    push_event(0, 1'b1, 3, 2, 5, -1);
    calc_rand(KR);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (KR) @(negedge clk);
    rexact = 1'b1;
    lvl[2] = 1'b1;
    wait_drain(0, 2000, "t5_restart");
    wait_rand_idle("t5_rand");
    chk("t5_rand_event_seen", rexact, 0);

    repeat (20) @(negedge clk);
    chk("sb_leftover", expq[0].size() + expq[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
